// File: rtl/prbs5_lfsr_checker.sv
// Receive-side checker for the 5-bit Galois LFSR pattern (x^5+x^2+1): seeds from data, verifies, then flywheels.
// Latency: every output is registered and reflects a word in the cycle after its in_valid.
// Backpressure: none; words are accepted whenever in_valid=1 and idle cycles freeze the checker.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset (highest priority)
//   in_valid/in_state  received 5-bit LFSR state word and its qualifier
//   clear_cnt          synchronous clear of err_count
//   locked             checker is in LOCKED
//   err_pulse          one-cycle flag for a mismatched word while locked
//   err_count          saturating count of locked-state mismatches
//   sync_st            FSM state: 00 SEARCH, 01 VERIFY, 10 LOCKED
module prbs5_lfsr_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [4:0]       in_state,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       sync_st
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    localparam logic [3:0] LOCK_V   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_CNT);

    function automatic logic [4:0] lfsr_step(input logic [4:0] s);
        return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       pred_q, pred_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       bad_cnt_q, bad_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             w_hit;
    logic             w_nz;
    logic [3:0]       match_inc;
    logic [3:0]       bad_inc;
    logic             count_err;

    assign w_hit     = (in_state == pred_q);
    assign w_nz      = (in_state != 5'd0);
    assign match_inc = match_cnt_q + 4'd1;
    assign bad_inc   = bad_cnt_q + 4'd1;

    // State register (plus the datapath registers that travel with it)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            pred_q      <= 5'd0;
            match_cnt_q <= 4'd0;
            bad_cnt_q   <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (w_nz) state_d = ST_VERIFY;
                end
                ST_VERIFY: begin
                    if (w_hit) begin
                        if (match_inc == LOCK_V) state_d = ST_LOCKED;
                    end else if (!w_nz) begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (!w_hit && (bad_inc == UNLOCK_V)) state_d = ST_SEARCH;
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        err_pulse_d = 1'b0;
        count_err   = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (w_nz) begin
                        pred_d      = lfsr_step(in_state);
                        match_cnt_d = 4'd0;
                    end
                end
                ST_VERIFY: begin
                    // bad_cnt is cleared here so LOCKED always starts with a clean miss run
                    bad_cnt_d = 4'd0;
                    if (w_hit) begin
                        match_cnt_d = match_inc;
                        pred_d      = lfsr_step(in_state);
                    end else if (w_nz) begin
                        match_cnt_d = 4'd0;
                        pred_d      = lfsr_step(in_state);
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: prediction free-runs, received data is never used as a seed
                    pred_d = lfsr_step(pred_q);
                    if (w_hit) begin
                        bad_cnt_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        count_err   = 1'b1;
                        bad_cnt_d   = bad_inc;
                    end
                end
                default: ;
            endcase
        end

        // A clear coinciding with a counted error leaves exactly that one error
        err_count_d = err_count_q;
        if (clear_cnt) begin
            err_count_d = count_err ? CNT_W'(1) : '0;
        end else if (count_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end

        locked_d = (state_d == ST_LOCKED);
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign sync_st   = state_q;

endmodule

// File: tb/tb_prbs5_lfsr_checker.sv
module tb_prbs5_lfsr_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] in_state = 5'd0;
    logic       clear_cnt = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [1:0] sync_st;

    int n_checks = 0;
    int n_fail   = 0;

    prbs5_lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_state  (in_state),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .sync_st   (sync_st)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] nxt(input logic [4:0] s);
        return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present inputs for one clock edge, then look at outputs #1 after that edge.
    task automatic drive(input logic v, input logic [4:0] w, input logic clr);
        in_valid  = v;
        in_state  = w;
        clear_cnt = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_cnt = 1'b0;
    endtask

    task automatic send(input logic [4:0] w);
        drive(1'b1, w, 1'b0);
    endtask

    logic [4:0] good_seq [8];
    logic       lock_exp [5];
    logic [4:0] s;
    int         exp_cnt;

    initial begin
        good_seq = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h05, 5'h0A, 5'h14};
        lock_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        rst = 1'b1;
        drive(1'b0, 5'd0, 1'b0);
        drive(1'b1, 5'h01, 1'b0);
        rst = 1'b0;
        chk("rst_locked", locked, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_count", err_count, 0);
        chk("rst_state", sync_st, 0);

        // 1: good stream locks after 5 words
        for (int i = 0; i < 5; i++) begin
            send(good_seq[i]);
            chk("t1_locked", locked, lock_exp[i]);
            if (i == 0) chk("t1_verify", sync_st, 2'b01);
        end
        chk("t1_state", sync_st, 2'b10);
        chk("t1_count", err_count, 0);

        // 2: one corrupted word (05 expected, 07 sent)
        send(5'h07);
        chk("t2_pulse", err_pulse, 1);
        chk("t2_count", err_count, 1);
        chk("t2_locked", locked, 1);
        send(5'h0A);
        chk("t2_pulse_next", err_pulse, 0);
        chk("t2_count_next", err_count, 1);
        send(5'h14);
        chk("t2_count_14", err_count, 1);
        drive(1'b0, 5'd0, 1'b1);
        chk("t2_clear", err_count, 0);

        // 3: three consecutive misses drop lock (predictions 0D,1A,11)
        send(5'h1F);
        chk("t3_cnt1", err_count, 1);
        send(5'h1F);
        chk("t3_cnt2", err_count, 2);
        chk("t3_lock2", locked, 1);
        send(5'h1F);
        chk("t3_cnt3", err_count, 3);
        chk("t3_unlock", locked, 0);
        chk("t3_search", sync_st, 2'b00);
        for (int i = 0; i < 5; i++) begin
            send(good_seq[i]);
            chk("t3_relock", locked, lock_exp[i]);
        end
        chk("t3_cnt_kept", err_count, 3);

        // 6: gaps while locked do not advance the prediction, then reset
        drive(1'b0, 5'h1F, 1'b0);
        drive(1'b0, 5'h1F, 1'b0);
        drive(1'b0, 5'h1F, 1'b0);
        chk("t6_gap_locked", locked, 1);
        send(5'h05);
        chk("t6_gap_pulse", err_pulse, 0);
        chk("t6_gap_count", err_count, 3);
        send(5'h00);
        chk("t6_miss_pulse", err_pulse, 1);
        rst = 1'b1;
        drive(1'b1, 5'h14, 1'b0);
        rst = 1'b0;
        chk("t6_rst_locked", locked, 0);
        chk("t6_rst_pulse", err_pulse, 0);
        chk("t6_rst_count", err_count, 0);
        chk("t6_rst_state", sync_st, 2'b00);

        // 4: all-zero input never seeds
        for (int i = 0; i < 10; i++) send(5'h00);
        chk("t4_state", sync_st, 2'b00);
        chk("t4_locked", locked, 0);
        chk("t4_count", err_count, 0);
        // VERIFY reseed on nonzero miss, fall back to SEARCH on zero
        send(5'h03);
        chk("t4_seed", sync_st, 2'b01);
        send(5'h09);
        chk("t4_reseed", sync_st, 2'b01);
        send(5'h12);
        chk("t4_reseed_hit", sync_st, 2'b01);
        chk("t4_no_err", err_count, 0);
        send(5'h00);
        chk("t4_zero_search", sync_st, 2'b00);

        // 5: saturate err_count, keeping lock with a good word after each miss pair
        for (int i = 0; i < 5; i++) send(good_seq[i]);
        chk("t5_locked", locked, 1);
        s = 5'h05;
        exp_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            send(s ^ 5'h1F);
            s = nxt(s);
            exp_cnt++;
            if (i == 9) chk("t5_cnt10", err_count, exp_cnt);
            if ((i % 2) == 1 || i == 254) begin
                send(s);
                s = nxt(s);
            end
        end
        chk("t5_cnt_ff", err_count, 8'hFF);
        chk("t5_still_locked", locked, 1);
        send(s ^ 5'h1F);
        s = nxt(s);
        chk("t5_sat", err_count, 8'hFF);
        chk("t5_sat_pulse", err_pulse, 1);
        send(s);
        s = nxt(s);
        drive(1'b1, s ^ 5'h1F, 1'b1);
        s = nxt(s);
        chk("t5_clear_err", err_count, 1);
        chk("t5_clear_lock", locked, 1);
        drive(1'b1, s, 1'b1);
        chk("t5_clear_only", err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
